// File: rtl/pattern_sequencer.sv
// pattern_sequencer: plays a latched bit pattern on a single output, LSB first.
// Each bit is held for a programmable number of clock cycles; the pattern repeats for a
// programmable number of passes, or forever when the repeat count is zero.
//
// Ports:
//   i_clk           sole clock, rising edge
//   i_rst           synchronous active-high reset, overrides all other inputs
//   i_cfg_valid     configuration offered
//   o_cfg_ready     high in IDLE; a config is accepted when valid & ready
//   i_cfg_pattern   bits to play, bit 0 first
//   i_cfg_len       bits per pass minus 1
//   i_cfg_prescale  clock cycles per bit (0 treated as 1)
//   i_cfg_repeat    passes to play, 0 = infinite
//   i_abort         stop playback (ignored in IDLE), no done pulse
//   o_out           registered pattern bit
//   o_busy          high in RUN
//   o_done          one-cycle pulse on natural completion
//   o_bit_idx       index of the bit currently on o_out
module pattern_sequencer #(
    parameter int unsigned PAT_W = 32,
    parameter int unsigned PRE_W = 32,
    localparam int unsigned LEN_W = $clog2(PAT_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic [PRE_W-1:0] i_cfg_prescale,
    input  logic [7:0]       i_cfg_repeat,
    input  logic             i_abort,
    output logic             o_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_bit_idx
);

    typedef enum logic [0:0] {StIdle = 1'b0, StRun = 1'b1} state_e;

    localparam logic [LEN_W-1:0] IdxOne  = LEN_W'(1);
    localparam logic [PRE_W-1:0] PreOne  = PRE_W'(1);
    localparam logic [7:0]       PassOne = 8'd1;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    // Prescale is stored as its reload value (P-1), so the counter never needs P itself.
    logic [PRE_W-1:0]   pre_rld_q, pre_rld_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    // Remaining passes; 0 means infinite and is never decremented.
    logic [7:0]         pass_cnt_q, pass_cnt_d;
    logic [LEN_W-1:0]   bit_idx_q, bit_idx_d;
    logic               out_q, out_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   idx_inc;
    logic [PRE_W-1:0]   cfg_rld;

    assign idx_inc = bit_idx_q + IdxOne;
    // prescale 0 and 1 both give a one-cycle bit
    assign cfg_rld = (i_cfg_prescale == '0) ? '0 : i_cfg_prescale - PreOne;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        pre_rld_d  = pre_rld_q;
        pre_cnt_d  = pre_cnt_q;
        pass_cnt_d = pass_cnt_q;
        bit_idx_d  = bit_idx_q;
        out_d      = out_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_cfg_valid) begin
                    state_d    = StRun;
                    pat_d      = i_cfg_pattern;
                    len_d      = i_cfg_len;
                    pre_rld_d  = cfg_rld;
                    pre_cnt_d  = cfg_rld;
                    pass_cnt_d = i_cfg_repeat;
                    bit_idx_d  = '0;
                    out_d      = i_cfg_pattern[0];
                end
            end
            StRun: begin
                if (i_abort) begin
                    // Abort wins over everything, including a completion this cycle.
                    state_d   = StIdle;
                    bit_idx_d = '0;
                    out_d     = 1'b0;
                end else if (pre_cnt_q != '0) begin
                    pre_cnt_d = pre_cnt_q - PreOne;
                end else if (bit_idx_q != len_q) begin
                    bit_idx_d = idx_inc;
                    out_d     = pat_q[idx_inc];
                    pre_cnt_d = pre_rld_q;
                end else if (pass_cnt_q != PassOne) begin
                    // End of a pass with more to go (or infinite): wrap without a gap.
                    bit_idx_d = '0;
                    out_d     = pat_q[0];
                    pre_cnt_d = pre_rld_q;
                    if (pass_cnt_q != '0) begin
                        pass_cnt_d = pass_cnt_q - PassOne;
                    end
                end else begin
                    state_d   = StIdle;
                    bit_idx_d = '0;
                    out_d     = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            pat_q      <= '0;
            len_q      <= '0;
            pre_rld_q  <= '0;
            pre_cnt_q  <= '0;
            pass_cnt_q <= '0;
            bit_idx_q  <= '0;
            out_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            pre_rld_q  <= pre_rld_d;
            pre_cnt_q  <= pre_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            bit_idx_q  <= bit_idx_d;
            out_q      <= out_d;
            done_q     <= done_d;
        end
    end

    assign o_cfg_ready = (state_q == StIdle);
    assign o_busy      = (state_q == StRun);
    assign o_out       = out_q;
    assign o_done      = done_q;
    assign o_bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer (PAT_W = PRE_W = 32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pattern_sequencer;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_pattern;
    logic [4:0]  cfg_len;
    logic [31:0] cfg_prescale;
    logic [7:0]  cfg_repeat;
    logic        abort;
    logic        out;
    logic        busy;
    logic        done;
    logic [4:0]  bit_idx;

    int n_checks = 0;
    int n_errors = 0;

    pattern_sequencer #(
        .PAT_W(32),
        .PRE_W(32)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cfg_valid   (cfg_valid),
        .o_cfg_ready   (cfg_ready),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_cfg_prescale(cfg_prescale),
        .i_cfg_repeat  (cfg_repeat),
        .i_abort       (abort),
        .o_out         (out),
        .o_busy        (busy),
        .o_done        (done),
        .o_bit_idx     (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a config in the current cycle (N); returns positioned in cycle N+1.
    task automatic start_cfg(input logic [31:0] pat, input logic [4:0] len,
                             input logic [31:0] pre, input logic [7:0] rep);
        cfg_pattern  = pat;
        cfg_len      = len;
        cfg_prescale = pre;
        cfg_repeat   = rep;
        cfg_valid    = 1'b1;
        check("start ready", {31'd0, cfg_ready}, 32'd1);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pat;
        logic [4:0]  eidx;
        logic [7:0]  exp_t1;

        rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_prescale = '0; cfg_repeat = '0; abort = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst ready", {31'd0, cfg_ready}, 32'd1);
        check("rst busy",  {31'd0, busy},      32'd0);
        check("rst out",   {31'd0, out},       32'd0);
        check("rst done",  {31'd0, done},      32'd0);
        check("rst idx",   {27'd0, bit_idx},   32'd0);

        // T1: 4'b1010, len 3, P = 2, one pass -> 0,0,1,1,0,0,1,1
        exp_t1 = 8'b11001100;
        start_cfg(32'hA, 5'd3, 32'd2, 8'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t1 out N+%0d", k + 1), {31'd0, out}, {31'd0, exp_t1[k]});
            check($sformatf("t1 busy N+%0d", k + 1), {31'd0, busy}, 32'd1);
            check($sformatf("t1 done N+%0d", k + 1), {31'd0, done}, 32'd0);
            step();
        end
        check("t1 done N+9",  {31'd0, done},      32'd1);
        check("t1 ready N+9", {31'd0, cfg_ready}, 32'd1);
        check("t1 out N+9",   {31'd0, out},       32'd0);
        step();
        check("t1 done N+10", {31'd0, done}, 32'd0);

        // T2: 8'hF0, len 7, P = 0 (acts as 1), two passes
        pat = 32'hF0;
        start_cfg(pat, 5'd7, 32'd0, 8'd2);
        for (int k = 1; k <= 16; k++) begin
            eidx = 5'((k - 1) % 8);
            check($sformatf("t2 out N+%0d", k), {31'd0, out}, {31'd0, pat[eidx]});
            check($sformatf("t2 idx N+%0d", k), {27'd0, bit_idx}, {27'd0, eidx});
            check($sformatf("t2 done N+%0d", k), {31'd0, done}, 32'd0);
            step();
        end
        check("t2 done N+17", {31'd0, done}, 32'd1);
        step();
        check("t2 done N+18", {31'd0, done}, 32'd0);

        // T3: infinite repeat, P = 3, abort at N+50
        pat = 32'h5;
        start_cfg(pat, 5'd3, 32'd3, 8'd0);
        for (int k = 1; k < 50; k++) begin
            check($sformatf("t3 done N+%0d", k), {31'd0, done}, 32'd0);
            step();
        end
        // bit ((50-1)/3) % 4 = 16 % 4 = 0 -> pattern bit 0 = 1
        check("t3 out N+50",  {31'd0, out},     32'd1);
        check("t3 idx N+50",  {27'd0, bit_idx}, 32'd0);
        check("t3 busy N+50", {31'd0, busy},    32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t3 out N+51",  {31'd0, out},  32'd0);
        check("t3 busy N+51", {31'd0, busy}, 32'd0);
        check("t3 done N+51", {31'd0, done}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            check("t3 done after abort", {31'd0, done}, 32'd0);
            step();
        end

        // T4: config offered mid-run is ignored
        start_cfg(32'hA, 5'd3, 32'd2, 8'd1);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                cfg_pattern = 32'h5;
                cfg_len     = 5'd1;
                cfg_valid   = 1'b1;
                check("t4 ready N+5", {31'd0, cfg_ready}, 32'd0);
            end
            if (k == 5) cfg_valid = 1'b0;
            check($sformatf("t4 out N+%0d", k + 1), {31'd0, out}, {31'd0, exp_t1[k]});
            step();
        end
        check("t4 done N+9", {31'd0, done}, 32'd1);
        step();

        // T5: 32-bit pass, P = 1, two passes
        pat = 32'h8000_0001;
        start_cfg(pat, 5'd31, 32'd1, 8'd2);
        for (int k = 1; k <= 64; k++) begin
            eidx = 5'((k - 1) % 32);
            check($sformatf("t5 out N+%0d", k), {31'd0, out}, {31'd0, pat[eidx]});
            check($sformatf("t5 idx N+%0d", k), {27'd0, bit_idx}, {27'd0, eidx});
            step();
        end
        check("t5 done N+65", {31'd0, done}, 32'd1);
        step();

        // T6: reset mid-run, then a new config plays normally
        start_cfg(32'hA, 5'd3, 32'd2, 8'd1);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6 out N+5",   {31'd0, out},       32'd0);
        check("t6 ready N+5", {31'd0, cfg_ready}, 32'd1);
        check("t6 busy N+5",  {31'd0, busy},      32'd0);
        check("t6 idx N+5",   {27'd0, bit_idx},   32'd0);
        check("t6 done N+5",  {31'd0, done},      32'd0);
        pat = 32'hF0;
        start_cfg(pat, 5'd7, 32'd0, 8'd1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("t6 out M+%0d", k), {31'd0, out}, {31'd0, pat[k-1]});
            step();
        end
        check("t6 done M+9", {31'd0, done}, 32'd1);
        step();

        // T7: config offered during reset is discarded
        cfg_pattern = 32'hFFFF_FFFF; cfg_len = 5'd3; cfg_prescale = 32'd0; cfg_repeat = 8'd1;
        cfg_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cfg_valid = 1'b0;
        check("t7 busy",  {31'd0, busy},      32'd0);
        check("t7 ready", {31'd0, cfg_ready}, 32'd1);
        check("t7 out",   {31'd0, out},       32'd0);

        // T8: abort in IDLE is ignored and the handshake is taken
        abort = 1'b1;
        start_cfg(32'h1, 5'd1, 32'd0, 8'd1);
        abort = 1'b0;
        check("t8 busy", {31'd0, busy}, 32'd1);
        check("t8 out",  {31'd0, out},  32'd1);
        step();
        check("t8 out N+2", {31'd0, out}, 32'd0);
        step();
        check("t8 done N+3", {31'd0, done}, 32'd1);
        step();

        // T9: abort coinciding with natural completion suppresses done
        start_cfg(32'h1, 5'd0, 32'd0, 8'd1);
        check("t9 busy N+1", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t9 done N+2", {31'd0, done}, 32'd0);
        check("t9 busy N+2", {31'd0, busy}, 32'd0);
        step();
        check("t9 done N+3", {31'd0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter PAT_W, default 32, meaning pattern register width in bits (power of two, 2..32).
REQ-002 SHALL have parameter PRE_W, default 32, meaning prescale counter width.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_cfg_valid  input  1  config offered.
REQ-006 SHALL have port o_cfg_ready  output  1  config accepted this cycle if valid.
REQ-007 SHALL have port i_cfg_pattern  input  PAT_W  bits to play, bit 0 first.
REQ-008 SHALL have port i_cfg_len  input  log2(PAT_W)  bits per pass minus 1.
REQ-009 SHALL have port i_cfg_prescale  input  PRE_W  i_clk cycles per bit.
REQ-010 SHALL have port i_cfg_repeat  input  8  passes to play; 0 means infinite.
REQ-011 SHALL have port i_abort  input  1  stop playback.
REQ-012 SHALL have port o_out  output  1  registered pattern bit, drives pin/LED.
REQ-013 SHALL have port o_busy  output  1  high in RUN.
REQ-014 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port o_bit_idx  output  log2(PAT_W)  index of bit on o_out.

Function
REQ-016 SHALL implement two states, IDLE and RUN; o_cfg_ready = (state == IDLE), o_busy = (state == RUN), both decoded from the state register only.
REQ-017 SHALL, in IDLE on i_cfg_valid & o_cfg_ready (cycle N), latch pattern, len, prescale and repeat, and enter RUN at N+1.
REQ-018 SHALL present o_out = pattern[0], o_bit_idx = 0 from cycle N+1 (one-cycle latency).
REQ-019 SHALL hold each bit for exactly P cycles, where P = latched prescale, and P = 1 when prescale = 0.
REQ-020 SHALL, after P cycles on bit k < len, advance to bit k+1 with no idle cycle.
REQ-021 SHALL, after P cycles on bit len, wrap to bit 0 with no gap when passes remain or repeat = 0; one pass SHALL therefore last (len+1)*P cycles.
REQ-022 SHALL, after the last bit of the final pass, enter IDLE with o_out = 0, o_bit_idx = 0, and o_done = 1 for exactly that first IDLE cycle.
REQ-023 SHALL count passes in an 8-bit down-counter; repeat = 0 SHALL never terminate and SHALL never pulse o_done.
REQ-024 SHALL ignore i_cfg_valid in RUN; latched config SHALL NOT change mid-run.
REQ-025 SHALL, on i_abort in RUN, enter IDLE next cycle with o_out = 0, o_bit_idx = 0, and no o_done pulse.
REQ-026 SHALL ignore i_abort in IDLE; a handshake in the same cycle SHALL still be accepted.
REQ-027 SHALL give i_abort priority over natural completion in the same cycle (no o_done).
REQ-028 SHALL use no arithmetic wider than PRE_W; the prescale counter SHALL count down from P-1 to 0 without overflow for P = 2^PRE_W-1.

Reset
REQ-029 SHALL, when i_rst is sampled high, set state = IDLE, o_out = 0, o_done = 0, o_bit_idx = 0, all counters and latched config = 0; o_cfg_ready = 1 and o_busy = 0 from the next cycle.
REQ-030 SHALL give i_rst priority over all other inputs, including mid-RUN and during a handshake; a config offered in a reset cycle SHALL be discarded.

Verification
REQ-031 SHALL cover: pattern 4'b1010, len = 3, prescale = 2, repeat = 1, accepted at N -> o_out = 0,0,1,1,0,0,1,1 over N+1..N+8; o_done = 1 and o_cfg_ready = 1 at N+9.
REQ-032 SHALL cover: pattern 8'hF0, len = 7, prescale = 0, repeat = 2 -> o_out = 0000111100001111 over N+1..N+16; o_done at N+17 only.
REQ-033 SHALL cover: repeat = 0, prescale = 3, i_abort at N+50 -> o_out = 0 and o_busy = 0 at N+51; o_done stays 0 forever.
REQ-034 SHALL cover: i_cfg_valid with a different pattern at N+5 of a run -> o_cfg_ready = 0 and the output stream is unchanged.
REQ-035 SHALL cover: len = 31, pattern 32'h8000_0001, prescale = 1, repeat = 2 -> o_bit_idx wraps 31 -> 0 at N+33; o_out = 1 at N+1, N+32, N+33 and N+64.
REQ-036 SHALL cover: i_rst at N+4 of a run -> reset values at N+5; a new config accepted at N+5 plays normally.
